// File: rtl/mod_n_count_checker.sv
// Monitors a mod-N count bus: locks onto the sequence, then flags skips, stalls,
// out-of-range values and bad wraps, and keeps error and wrap statistics.
module mod_n_count_checker #(
    parameter int unsigned MOD      = 13,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam int unsigned      RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] match_run;

    logic [WIDTH-1:0] exp_c;
    logic             in_range_c;
    logic             match_c;
    logic             err_c;
    logic             wrap_c;

    // Expected successor and per-sample classification
    always_comb begin
        exp_c      = (prev == LAST) ? '0 : prev + WIDTH'(1);
        in_range_c = ({1'b0, count_in} < MOD_EXT);
        match_c    = in_range_c && (count_in == exp_c);
        err_c      = en && (state == LOCKED) && !match_c;
        wrap_c     = en && (state == LOCKED) && match_c && (prev == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            prev       <= '0;
            match_run  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            err_pulse  <= err_c;
            wrap_pulse <= wrap_c;

            if (en) begin
                unique case (state)
                    SEARCH: begin
                        if (in_range_c) begin
                            prev      <= count_in;
                            match_run <= '0;
                            state     <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (match_c) begin
                            prev      <= count_in;
                            match_run <= match_run + RUN_W'(1);
                            if (match_run + RUN_W'(1) == RUN_LOCK) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (in_range_c) begin
                            prev      <= count_in;
                            match_run <= '0;
                        end else begin
                            match_run <= '0;
                            state     <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        if (match_c) begin
                            prev <= count_in;
                        end else begin
                            locked    <= 1'b0;
                            match_run <= '0;
                            if (in_range_c) begin
                                prev  <= count_in;
                                state <= ACQ;
                            end else begin
                                state <= SEARCH;
                            end
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        match_run <= '0;
                    end
                endcase
            end

            // Statistics; a clear still counts an event landing on the same edge
            if (clr) begin
                err_cnt    <= ERR_W'(err_c);
                err_sticky <= err_c;
                wrap_cnt   <= WRAP_W'(wrap_c);
            end else begin
                if (err_c) begin
                    err_sticky <= 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                end
                if (wrap_c) begin
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_n_count_checker.sv
// Directed + randomized bench for mod_n_count_checker against a transition-history model.
module tb_mod_n_count_checker;

    localparam int MOD      = 13;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int ERR_W    = 8;
    localparam int WRAP_W   = 8;
    localparam int SAT_W    = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             clr;

    logic              locked, err_pulse, err_sticky, wrap_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

    logic              s_locked, s_err_pulse, s_err_sticky, s_wrap_pulse;
    logic [SAT_W-1:0]  s_err_cnt;
    logic [WRAP_W-1:0] s_wrap_cnt;

    mod_n_count_checker #(
        .MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    mod_n_count_checker #(
        .MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(SAT_W), .WRAP_W(WRAP_W)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr(clr),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_sticky(s_err_sticky),
        .err_cnt(s_err_cnt), .wrap_pulse(s_wrap_pulse), .wrap_cnt(s_wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: anchor value plus the number of consecutive correct transitions since it
    bit m_valid;
    int m_prev;
    int m_run;
    int m_errs;
    int m_wraps;
    bit m_err;
    bit m_wrap;
    int cur;

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        checks++;
        assert (got === 32'(expv)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_prev = 0; m_run = 0;
        m_errs = 0; m_wraps = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit e, input int v, input bit c);
        bit was_locked;
        m_err  = 0;
        m_wrap = 0;
        if (e) begin
            if (!m_valid) begin
                if (v < MOD) begin
                    m_valid = 1; m_prev = v; m_run = 0;
                end
            end else begin
                was_locked = (m_run >= LOCK_CNT);
                if (v == (m_prev + 1) % MOD) begin
                    m_wrap = was_locked && (m_prev == MOD - 1);
                    m_prev = v;
                    if (m_run < 1000) m_run++;
                end else begin
                    m_err = was_locked;
                    m_run = 0;
                    if (v < MOD) m_prev = v;
                    else m_valid = 0;
                end
            end
        end
        if (c) begin
            m_errs  = m_err;
            m_wraps = m_wrap;
        end else begin
            m_errs  = m_errs + m_err;
            m_wraps = (m_wraps + m_wrap) % (1 << WRAP_W);
        end
    endtask

    task automatic check_all();
        int exp_locked;
        exp_locked = (m_valid && m_run >= LOCK_CNT) ? 1 : 0;
        check("locked",     32'(locked),       exp_locked);
        check("err_pulse",  32'(err_pulse),    m_err);
        check("err_sticky", 32'(err_sticky),   (m_errs > 0) ? 1 : 0);
        check("err_cnt",    32'(err_cnt),      (m_errs > 255) ? 255 : m_errs);
        check("wrap_pulse", 32'(wrap_pulse),   m_wrap);
        check("wrap_cnt",   32'(wrap_cnt),     m_wraps);
        check("sat_err_cnt", 32'(s_err_cnt),   (m_errs > 3) ? 3 : m_errs);
        check("sat_locked", 32'(s_locked),     exp_locked);
    endtask

    // One sampled edge: drive, clock, model, then check 1 time unit after the edge
    task automatic cyc(input bit e, input int v, input bit c);
        en       = e;
        count_in = WIDTH'(v);
        clr      = c;
        @(posedge clk);
        model_step(e, v, c);
        #1;
        check_all();
    endtask

    task automatic count_to(input int v);
        do begin
            cur = (cur + 1) % MOD;
            cyc(1'b1, cur, 1'b0);
        end while (cur != v);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; count_in = '0; clr = 1'b0;
        model_reset();
        #3;
        check_all();
        #5;
        check_all();
        #2;
        rst = 1'b1;

        // Clean count from 0: lock after the third sample, then wrap every 12->0
        cur = 0;
        cyc(1'b1, 0, 1'b0);
        count_to(2);
        check("lock_after_3", 32'(locked), 1);
        repeat (30) begin
            cur = (cur + 1) % MOD;
            cyc(1'b1, cur, 1'b0);
        end

        // Skip 5 -> 7, relock on 9
        count_to(5);
        cur = 7; cyc(1'b1, 7, 1'b0);
        check("skip_err_pulse", 32'(err_pulse), 1);
        count_to(9);
        check("skip_relock", 32'(locked), 1);

        // Out-of-range then resume
        count_to(3);
        cyc(1'b1, 13, 1'b0);
        cur = 12;
        count_to(2);

        // Stall 4,4 then recover
        count_to(4);
        cyc(1'b1, 4, 1'b0);
        count_to(6);

        // Bad wrap 12 -> 13, then a good wrap 12 -> 0
        count_to(12);
        cyc(1'b1, 13, 1'b0);
        cur = 12;
        count_to(2);
        count_to(12);
        count_to(0);
        check("good_wrap", 32'(wrap_pulse), 1);

        // en gating with frozen and with garbage input
        repeat (5) cyc(1'b0, cur, 1'b0);
        repeat (5) cyc(1'b0, $urandom_range(0, 15), 1'b0);
        count_to(5);

        // clr coinciding with an injected error
        cur = 8; cyc(1'b1, 8, 1'b1);
        check("clr_err_cnt", 32'(err_cnt), 1);
        check("clr_wrap_cnt", 32'(wrap_cnt), 0);
        count_to(12);
        count_to(0);
        cyc(1'b1, 1, 1'b0); cur = 1;

        // Five errors to saturate the narrow counter
        repeat (5) begin
            cur = (cur + 2) % MOD;
            cyc(1'b1, cur, 1'b0);
            count_to((cur + 2) % MOD);
        end
        check("sat_hold", 32'(s_err_cnt), 3);

        // Randomized stream: mostly legal successors with injected faults, gaps and clears
        repeat (500) begin
            int r, v;
            bit e, c;
            r = $urandom_range(0, 99);
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 39) == 0);
            v = (r < 85) ? (cur + 1) % MOD : $urandom_range(0, 15);
            if (e) cur = v;
            cyc(e, v, c);
        end

        // Ensure non-zero state, then assert reset mid-cycle
        cur = 12;
        count_to(4);
        count_to(12);
        count_to(0);
        cur = 3; cyc(1'b1, 3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        cur = 0;
        cyc(1'b1, 0, 1'b0);
        count_to(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
